div_sequencer: RTL
==================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; iteration count equals WIDTH.
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: RESET  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled only at a rising edge.
REQ-005 SHALL have port: op  input  5  ALU opcode: 01000 div, 01001 divu, 01010 rem, 01011 remu.
REQ-006 SHALL have port: dividend  input  WIDTH  rs1 operand.
REQ-007 SHALL have port: divisor  input  WIDTH  rs2 operand.
REQ-008 SHALL have port: flush  input  1  pipeline flush; aborts the operation in progress.
REQ-009 SHALL have port: busy  output  1  stall request to the pipeline; registered.
REQ-010 SHALL have port: valid  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port: result  output  WIDTH  quotient or remainder.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE; busy=1 only in BUSY; valid=1 only in DONE.
REQ-013 SHALL accept a request when start=1, op is one of the four divide opcodes, flush=0, and state is IDLE or DONE.
REQ-014 SHALL ignore start with any other op, and SHALL ignore start while in BUSY.
REQ-015 SHALL latch op, operand magnitudes and sign flags on the accepting edge.
REQ-016 SHALL run restoring radix-2 division, one quotient bit per edge in BUSY, using a 0..WIDTH-1 iteration counter.
REQ-017 SHALL enter BUSY on the accepting edge, leave BUSY on the WIDTH-th following edge, and so present valid in the cycle after the 32nd edge after acceptance.
REQ-018 SHALL treat div/rem operands as two's complement: quotient negated when the operand signs differ; remainder takes the dividend's sign.
REQ-019 SHALL treat divu/remu operands as unsigned with no sign correction.
REQ-020 SHALL, for divisor=0, go directly IDLE/DONE->DONE on the accepting edge, with quotient=all ones and remainder=dividend (both signed and unsigned).
REQ-021 SHALL, for signed overflow (dividend=0x80000000, divisor=0xFFFFFFFF, div/rem only), go directly to DONE with quotient=0x80000000 and remainder=0.
REQ-022 SHALL update result only on entry to DONE and hold it until the next entry to DONE.
REQ-023 SHALL leave DONE after one cycle: to IDLE, or to BUSY/DONE if a new request is accepted in that cycle (back-to-back).
REQ-024 SHALL, on flush=1 in any state, go to IDLE on that edge, produce no valid, leave result unchanged, and reject a start in the same cycle.
REQ-025 SHALL handle the dividend's most-negative value in signed magnitude form without overflow (33-bit partial remainder).

Reset
REQ-026 SHALL, when RESET=0 at an edge, force state=IDLE, busy=0, valid=0, result=0 and counter=0, overriding start and flush.
REQ-027 SHALL, on reset mid-operation, discard the operation and produce no later valid.
REQ-028 SHALL accept a request on the first edge with RESET=1.

Verification
REQ-029 SHALL cover: DIV 20/0xFFFFFFFD -> busy for 32 cycles, then valid with result=0xFFFFFFFA; REM of the same operands -> 0x00000002.
REQ-030 SHALL cover: DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU of the same operands -> 0x00000001; valid exactly 32 edges after acceptance.
REQ-031 SHALL cover: DIV 7/0 -> valid one cycle after acceptance, busy never high, result=0xFFFFFFFF; REM 7/0 -> 0x00000007.
REQ-032 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after one cycle; REM of the same operands -> 0.
REQ-033 SHALL cover: flush on the 10th BUSY cycle -> busy=0 next cycle, no valid, prior result held; a subsequent DIVU 9/3 -> 3.
REQ-034 SHALL cover: start during BUSY ignored; start asserted in the DONE cycle accepted back-to-back; RESET=0 mid-op -> all outputs 0, no valid.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle restoring radix-2 divider for div/divu/rem/remu.
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic             rem_op_r;

  logic             is_div_op;
  logic             op_signed;
  logic             accept;
  logic             dd_neg;
  logic             ds_neg;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] ds_mag;
  logic             div_zero;
  logic             sovf;
  logic [WIDTH-1:0] imm_res;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] quot_fin;
  logic [WIDTH-1:0] rem_fin;
  logic [WIDTH-1:0] fin_res;

  // Request decode and operand conditioning for the accepting edge
  always_comb begin
    is_div_op = (op[4:2] == 3'b010);
    op_signed = ~op[0];
    accept    = start && is_div_op && !flush && (state != S_BUSY);
    dd_neg    = op_signed & dividend[WIDTH-1];
    ds_neg    = op_signed & divisor[WIDTH-1];
    dd_mag    = dd_neg ? WIDTH'(-dividend) : dividend;
    ds_mag    = ds_neg ? WIDTH'(-divisor) : divisor;
    div_zero  = (divisor == '0);
    sovf      = op_signed && (dividend == SMIN) && (divisor == '1);
    imm_res   = '0;
    if (div_zero) begin
      imm_res = op[1] ? dividend : '1;
    end else if (sovf) begin
      imm_res = op[1] ? '0 : SMIN;
    end
  end

  // One restoring step; the 33-bit shifted remainder absorbs the most-negative magnitude
  always_comb begin
    shifted  = {1'b0, rem_r, q_r[WIDTH-1]};
    ge       = (shifted >= {1'b0, dvs_r});
    rem_nxt  = ge ? WIDTH'(shifted - {1'b0, dvs_r}) : shifted[WIDTH-1:0];
    q_nxt    = {q_r[WIDTH-2:0], ge};
    quot_fin = q_neg_r ? WIDTH'(-q_nxt) : q_nxt;
    rem_fin  = r_neg_r ? WIDTH'(-rem_nxt) : rem_nxt;
    fin_res  = rem_op_r ? rem_fin : quot_fin;
  end

  // Sequencer: reset beats flush beats everything else
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= '0;
      cnt      <= '0;
      q_r      <= '0;
      rem_r    <= '0;
      dvs_r    <= '0;
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      rem_op_r <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_BUSY: begin
          q_r   <= q_nxt;
          rem_r <= rem_nxt;
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            valid  <= 1'b1;
            result <= fin_res;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
          if (accept) begin
            q_r      <= dd_mag;
            rem_r    <= '0;
            dvs_r    <= ds_mag;
            q_neg_r  <= dd_neg ^ ds_neg;
            r_neg_r  <= dd_neg;
            rem_op_r <= op[1];
            cnt      <= '0;
            if (div_zero || sovf) begin
              state  <= S_DONE;
              valid  <= 1'b1;
              result <= imm_res;
            end else begin
              state <= S_BUSY;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
